burst_mem_responder: RTL and testbench
======================================

Name: burst_mem_responder

Overview:
- Synthesizable responder for the physical-memory side of the core's 64-bit burst memory port: it answers the cache line fill and writeback traffic produced by the memory hierarchy.
- Serves each mem_read or mem_write as one 4-beat burst of 64-bit words, i.e. one 256-bit cache line, after a programmable access latency.
- Holds line storage internally.
- Used as the memory model in top-level simulation and as on-chip backing memory in FPGA builds.

Parameters:
- DEPTH_LINES, 256: number of 32-byte lines stored; power of two; IDX_W = log2(DEPTH_LINES).
- LATENCY, 4: cycles from request accept to first beat; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_read  in  1  line read request, held by requester until the final beat.
- mem_write  in  1  line write request, held by requester until the final beat.
- mem_address  in  32  byte address; bits [4:0] ignored; line index = mem_address[5+IDX_W-1:5]; upper bits ignored, so addresses alias modulo DEPTH_LINES.
- mem_wdata  in  64  write beat data, sampled on beats.
- mem_resp  out  1  beat strobe, high exactly 4 consecutive cycles per transaction.
- mem_rdata  out  64  read beat data; 0 whenever mem_resp is low or the transaction is a write.
- protocol_err  out  1  one-cycle pulse flagging requester protocol violations.

Behaviour:
- States: IDLE, WAIT, BURST, TURN.
- Reset (rst low, async): state IDLE; mem_resp=0; mem_rdata=0; protocol_err=0; latency and beat counters cleared.
- Storage contents are not reset; they are retained across reset, and contents before the first write are undefined.
- IDLE, accept: a rising edge with mem_read|mem_write high is the accept edge.
- On accept: latch the line index and op (read wins if both are high), go to WAIT.
- Cycle numbering: the cycle after the accept edge is cycle 1.
- WAIT: count cycles; mem_resp is high in cycles LATENCY..LATENCY+3. The first of these enters BURST.
- BURST, beat i (i=0..3) covers word index {line, i[1:0]}.
  - Read: mem_rdata = stored word during the beat cycle.
  - Write: mem_wdata is written to the word at the rising edge that ends the beat cycle.
  - Beat 0 is the lowest-addressed 8 bytes.
- After beat 3 go to TURN for one cycle with mem_resp=0; requests are ignored there; then IDLE.
- Minimum spacing: a new accept can happen no earlier than the edge ending TURN, so back-to-back transactions are separated by at least one idle-resp cycle plus latency.
- mem_address and mem_wdata outside beats are don't-care.
- The address is sampled only at the accept edge; changes afterwards are ignored.
- Protocol errors, each pulsing protocol_err=1 for one cycle:
  - mem_read and mem_write both high at the accept edge: served as a read; pulse in cycle 1.
  - Latched op signal low at any rising edge in WAIT or BURST (before beat 3 completes): abort; go to TURN next cycle with mem_resp=0; pulse in that TURN cycle.
  - On abort, write beats already committed stay written and the remaining beats are not written.
- Opposite op signal rising mid-transaction is ignored and is not an error.
- Reset asserted mid-transaction forces IDLE immediately, with outputs as in reset. Any write beat whose edge had not occurred is not written.
- Only one transaction is in flight; no queuing.

Test Plan:
- LATENCY=4, write line 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_resp high in cycles 4-7 after accept, low in cycle 8. A read of 0x0000_0040 then returns the same four words in order in its cycles 4-7, and mem_rdata=0 outside them.
- Read 0x0000_0047 after the test above -> identical data to 0x0000_0040, since low 5 bits are ignored. With DEPTH_LINES=256, read 0x0000_2040 -> same line (alias).
- Requester drops mem_read after beat 1 -> mem_resp low from the next cycle; protocol_err pulses once; the next read is accepted normally after TURN.
- Write aborted after 2 beats over a line holding 0xAA..AA -> words 0-1 hold new data and words 2-3 still hold 0xAA..AA.
- mem_read=mem_write=1 at accept -> read data returned, protocol_err high only in cycle 1, storage unchanged.
- rst pulled low during beat 2 of a read -> mem_resp and mem_rdata go 0 without waiting for a clock edge. After release, a new request gets full LATENCY and 4 beats, and line contents are unchanged.

Source files
------------

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - 4-beat burst line memory responder with programmable latency
module burst_mem_responder #(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [63:0] mem_wdata,
    output logic        mem_resp,
    output logic [63:0] mem_rdata,
    output logic        protocol_err
);

    localparam int IDX_W = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        TURN
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       lat_cnt, lat_cnt_nx;
    logic [1:0]       beat, beat_nx;
    logic [IDX_W-1:0] line_idx, line_idx_nx;
    logic             op_read, op_read_nx;
    logic             err_nx;
    logic             wr_en;
    logic             req_any;
    logic             op_held;

    // Four 64-bit words per line; word address is {line, beat}.
    logic [63:0] store [0:DEPTH_LINES*4-1];

    // Address bits outside the line index are intentionally ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{mem_address[31:5+IDX_W], mem_address[4:0]};

    assign req_any = mem_read | mem_write;
    // Only the op that was latched at accept keeps the transaction alive.
    assign op_held = op_read ? mem_read : mem_write;

    // State and transaction context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            beat         <= '0;
            line_idx     <= '0;
            op_read      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nx;
            lat_cnt      <= lat_cnt_nx;
            beat         <= beat_nx;
            line_idx     <= line_idx_nx;
            op_read      <= op_read_nx;
            protocol_err <= err_nx;
        end
    end

    // Next-state, abort detection and write-beat commit decision.
    always_comb begin
        state_nx    = state;
        lat_cnt_nx  = lat_cnt;
        beat_nx     = beat;
        line_idx_nx = line_idx;
        op_read_nx  = op_read;
        err_nx      = 1'b0;
        wr_en       = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    line_idx_nx = mem_address[5+IDX_W-1:5];
                    op_read_nx  = mem_read;
                    err_nx      = mem_read & mem_write;
                    lat_cnt_nx  = 4'd1;
                    beat_nx     = 2'd0;
                    state_nx    = (LATENCY == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!op_held) begin
                    state_nx = TURN;
                    err_nx   = 1'b1;
                end else if (lat_cnt == 4'(LATENCY - 1)) begin
                    state_nx = BURST;
                    beat_nx  = 2'd0;
                end else begin
                    lat_cnt_nx = lat_cnt + 4'd1;
                end
            end
            BURST: begin
                // The final beat always completes; earlier beats need the op held.
                wr_en = !op_read && (op_held || beat == 2'd3);
                if (beat == 2'd3) begin
                    state_nx = TURN;
                end else if (!op_held) begin
                    state_nx = TURN;
                    err_nx   = 1'b1;
                end else begin
                    beat_nx = beat + 2'd1;
                end
            end
            TURN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Line storage write port; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[{line_idx, beat}] <= mem_wdata;
        end
    end

    assign mem_resp  = (state == BURST);
    assign mem_rdata = (state == BURST && op_read) ? store[{line_idx, beat}] : '0;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - randomized and directed self-checking bench for burst_mem_responder
module tb_burst_mem_responder;

    localparam int LAT  = 4;
    localparam int NONE = LAT + 4;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [63:0] mem_wdata;
    logic        mem_resp;
    logic [63:0] mem_rdata;
    logic        protocol_err;

    int n_pass;
    int n_total;
    int txn_no;

    logic [63:0] model [0:1023];
    logic [63:0] wbeats [4];
    logic [7:0]  lines [8];

    burst_mem_responder #(
        .DEPTH_LINES(256),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_resp(mem_resp),
        .mem_rdata(mem_rdata),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One transaction from accept through the idle cycle after TURN.
    // d: first cycle in which the requester holds both request lines low.
    // The reference: beats in cycles LAT..LAT+3, truncated to cycles <= d on abort.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input int d);
        int turn_c;
        int b;
        int widx;
        bit beat_on;
        bit aborted;
        logic [63:0] exp_rd;
        aborted = (d <= LAT + 2);
        turn_c  = aborted ? d + 1 : LAT + 4;
        widx    = int'(addr[12:5]) * 4;
        txn_no++;
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = {$urandom, $urandom};
        for (int c = 1; c <= turn_c + 1; c++) begin
            @(posedge clk);
            #1;
            if (c >= d) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            mem_address = $urandom;
            b = c - LAT;
            beat_on   = (c >= LAT) && (c <= LAT + 3) && (c < turn_c);
            mem_wdata = beat_on ? wbeats[b] : {$urandom, $urandom};
            exp_rd    = (beat_on && rd) ? model[widx + b] : 64'd0;
            chk($sformatf("t%0d_c%0d_resp", txn_no, c), {63'd0, mem_resp}, {63'd0, beat_on});
            chk($sformatf("t%0d_c%0d_rdata", txn_no, c), mem_rdata, exp_rd);
            chk($sformatf("t%0d_c%0d_err", txn_no, c), {63'd0, protocol_err},
                {63'd0, ((c == 1) && rd && wr) || (aborted && c == turn_c)});
            if (beat_on && !rd && c < d) model[widx + b] = wbeats[b];
        end
    endtask

    task automatic set_beats(input logic [63:0] w0, input logic [63:0] w1,
                             input logic [63:0] w2, input logic [63:0] w3);
        wbeats[0] = w0;
        wbeats[1] = w1;
        wbeats[2] = w2;
        wbeats[3] = w3;
    endtask

    initial begin
        int op;
        int d;
        logic [7:0] ln;
        logic [31:0] a;
        n_pass      = 0;
        n_total     = 0;
        txn_no      = 0;
        rst         = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp", {63'd0, mem_resp}, 64'd0);
        chk("reset_rdata", mem_rdata, 64'd0);
        chk("reset_err", {63'd0, protocol_err}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed: full write then reads, including ignored low bits and aliasing.
        set_beats({8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}});
        txn(1'b0, 1'b1, 32'h0000_0040, NONE);
        txn(1'b1, 1'b0, 32'h0000_0040, NONE);
        txn(1'b1, 1'b0, 32'h0000_0047, NONE);
        txn(1'b1, 1'b0, 32'h0000_2040, NONE);

        // Read dropped after beat 1, then a normal read.
        txn(1'b1, 1'b0, 32'h0000_0040, LAT + 1);
        txn(1'b1, 1'b0, 32'h0000_0040, NONE);

        // Write aborted after two beats over a line of 0xAA.
        set_beats({8{8'hAA}}, {8{8'hAA}}, {8{8'hAA}}, {8{8'hAA}});
        txn(1'b0, 1'b1, 32'h0000_0080, NONE);
        set_beats({8{8'h55}}, {8{8'h66}}, {8{8'h77}}, {8{8'h88}});
        txn(1'b0, 1'b1, 32'h0000_0080, LAT + 2);
        txn(1'b1, 1'b0, 32'h0000_0080, NONE);

        // Both requests at accept: served as read, storage untouched.
        txn(1'b1, 1'b1, 32'h0000_0040, NONE);
        txn(1'b1, 1'b0, 32'h0000_0040, NONE);

        // Reset during beat 2 of a read.
        mem_read    = 1'b1;
        mem_address = 32'h0000_0040;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(posedge clk);
            #1;
        end
        chk("rstmid_beat2_rdata", mem_rdata, model[10]);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_resp", {63'd0, mem_resp}, 64'd0);
        chk("rstmid_rdata", mem_rdata, 64'd0);
        chk("rstmid_err", {63'd0, protocol_err}, 64'd0);
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 32'h0000_0040, NONE);

        // Randomized traffic over a small set of fully initialised lines.
        for (int i = 0; i < 8; i++) begin
            lines[i] = 8'($urandom_range(3, 255));
            set_beats({$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom});
            txn(1'b0, 1'b1, {19'($urandom), lines[i], 5'($urandom)}, NONE);
        end
        for (int i = 0; i < 40; i++) begin
            ln = lines[$urandom_range(0, 7)];
            a  = {19'($urandom), ln, 5'($urandom)};
            op = $urandom_range(0, 5);
            d  = ($urandom_range(0, 1) == 0) ? NONE : $urandom_range(1, LAT + 2);
            set_beats({$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, {$urandom, $urandom});
            if (op < 2)      txn(1'b1, 1'b0, a, d);
            else if (op < 5) txn(1'b0, 1'b1, a, d);
            else             txn(1'b1, 1'b1, a, d);
        end
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 1'b0, {19'd0, lines[i], 5'd0}, NONE);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
